// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the multiplexed 4-digit BCD display scanner.
// The nibble helper applies optional leading-zero blanking to one digit.
package display_scan_controller_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_e;

    localparam int unsigned BIN_WIDTH  = 14;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_WIDTH  = 4 * NUM_DIGITS;

    localparam logic [3:0]           BLANK     = 4'hF;
    localparam logic [BIN_WIDTH-1:0] MAX_VALUE = 14'd9999;

    // A digit above the ones place is blank when it and every digit above it are zero.
    function automatic logic [3:0] scan_nibble(input logic [BCD_WIDTH-1:0] bcd,
                                               input logic [1:0]           idx,
                                               input logic                 blank_lz);
        logic [BCD_WIDTH-1:0] upper;
        upper = bcd >> {idx, 2'b00};
        if (blank_lz && (idx != 2'd0) && (upper == '0)) begin
            return BLANK;
        end
        return upper[3:0];
    endfunction

endpackage

// File: rtl/display_scan_controller_bin2bcd_seq.sv
// Sequential double-dabble converter: one adjust-and-shift per cycle, then a
// single COMMIT cycle in which done_o flags that bcd_o holds the final result.
module bin2bcd_seq
    import display_scan_controller_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [BIN_WIDTH-1:0] bin_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [BCD_WIDTH-1:0] bcd_o
);

    conv_state_e          state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_WIDTH-1:0] bcd_q, bcd_d;
    logic [3:0]           count_q, count_d;
    logic [BCD_WIDTH-1:0] adjusted;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        count_d  = count_q;
        adjusted = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    bin_d   = bin_i;
                    bcd_d   = '0;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Top bit of the adjusted value is always zero for inputs up to 9999.
                bcd_d   = BCD_WIDTH'({adjusted, bin_q[BIN_WIDTH-1]});
                bin_d   = {bin_q[BIN_WIDTH-2:0], 1'b0};
                count_d = count_q + 4'd1;
                if (count_q == 4'(BIN_WIDTH - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == COMMIT);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/display_scan_controller.sv
// Captures a clamped binary value, converts it to BCD, and time-multiplexes the
// four digits onto a shared nibble bus with a one-hot digit enable.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [BIN_WIDTH-1:0] bin_value_i,
    input  logic                 load_i,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic [3:0]           digit_value_o,
    output logic [3:0]           digit_sel_o
);

    localparam int unsigned          PRE_WIDTH = 20;
    localparam logic [PRE_WIDTH-1:0] PRE_LAST  = PRE_WIDTH'(SCAN_DIV - 1);

    logic                 conv_busy, conv_done, load_accept;
    logic [BCD_WIDTH-1:0] conv_bcd;
    logic [BIN_WIDTH-1:0] clamped;

    logic                 overflow_q, overflow_d;
    logic [BCD_WIDTH-1:0] display_q, display_d;
    logic [PRE_WIDTH-1:0] prescaler_q, prescaler_d;
    logic [1:0]           scan_idx_q, scan_idx_d;
    logic [3:0]           sel_q, sel_d;
    logic [3:0]           value_q, value_d;

    assign load_accept = load_i && !conv_busy;
    assign clamped     = (bin_value_i > MAX_VALUE) ? MAX_VALUE : bin_value_i;

    bin2bcd_seq u_bin2bcd (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (load_accept),
        .bin_i   (clamped),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Outputs are derived from next-state values so select and nibble move together
    // with the scan index and with the display register update.
    always_comb begin
        overflow_d  = overflow_q;
        display_d   = display_q;
        prescaler_d = prescaler_q + 1'b1;
        scan_idx_d  = scan_idx_q;

        if (load_accept) begin
            overflow_d = (bin_value_i > MAX_VALUE);
        end
        if (conv_done) begin
            display_d = conv_bcd;
        end
        if (prescaler_q == PRE_LAST) begin
            prescaler_d = '0;
            scan_idx_d  = scan_idx_q + 2'd1;
        end

        sel_d   = 4'b0001 << scan_idx_d;
        value_d = scan_nibble(display_d, scan_idx_d, BLANK_LZ);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q  <= 1'b0;
            display_q   <= '0;
            prescaler_q <= '0;
            scan_idx_q  <= '0;
            sel_q       <= 4'b0001;
            value_q     <= 4'h0;
        end else begin
            overflow_q  <= overflow_d;
            display_q   <= display_d;
            prescaler_q <= prescaler_d;
            scan_idx_q  <= scan_idx_d;
            sel_q       <= sel_d;
            value_q     <= value_d;
        end
    end

    assign busy_o        = conv_busy;
    assign overflow_o    = overflow_q;
    assign digit_sel_o   = sel_q;
    assign digit_value_o = value_q;

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving the clk cycles each digit stays selected (legal range 2..2^20-1).
REQ-002 The block SHALL have parameter BLANK_LZ, default 1; when 1, leading zeros are blanked.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 bin_value  input  14  unsigned binary value to display.
REQ-006 load  input  1  one-cycle strobe; capture bin_value and start conversion.
REQ-007 busy  output  1  high while binary-to-BCD conversion runs.
REQ-008 overflow  output  1  high while the displayed value was clamped.
REQ-009 digit_value  output  4  BCD nibble for the downstream 7-segment decoder; 4'hF means blank (decoder default is OFF).
REQ-010 digit_sel  output  4  one-hot active-high digit enable; bit 0 is the ones digit.

Function
REQ-011 On load with busy low, the block SHALL capture min(bin_value, 9999); overflow is set when bin_value > 9999, cleared otherwise.
REQ-012 A load asserted while busy is high SHALL be ignored.
REQ-013 Conversion SHALL use sequential shift-add-3 (double dabble), one shift per cycle: state IDLE -> SHIFT (14 cycles) -> COMMIT (1 cycle) -> IDLE.
REQ-014 Each SHIFT cycle SHALL add 3 to every BCD nibble >= 5 before the left shift.
REQ-015 busy SHALL rise the cycle after load and fall in the cycle after COMMIT, i.e. it is high for exactly 15 cycles.
REQ-016 In COMMIT the four BCD digits SHALL be copied atomically into the display register; the display is never shown a partially converted value.
REQ-017 A prescaler SHALL count 0..SCAN_DIV-1; at terminal count the scan index advances 0->1->2->3->0 and the prescaler wraps to 0.
REQ-018 digit_sel SHALL equal 1 << scan index; digit_value SHALL equal the display-register nibble for that index, both registered and changing in the same cycle.
REQ-019 With BLANK_LZ=1, digit i (i>0) SHALL output 4'hF when it and all higher digits are zero; the ones digit is never blanked (value 0 shows "0").
REQ-020 Scanning SHALL continue unaffected during conversion and on load; the scan phase is never reset by load.

Reset
REQ-021 While rst_n is low: state IDLE, busy 0, overflow 0, display register 0000, prescaler 0, scan index 0, digit_sel 4'b0001, digit_value per REQ-019 for value 0 (4'h0).
REQ-022 Reset asserted mid-conversion SHALL abort it; the display register returns to 0000.
REQ-023 After reset release, the first scan advance SHALL occur SCAN_DIV cycles later.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE, SHIFT, COMMIT), BLANK nibble constant 4'hF, MAX_VALUE 9999 and digit count 4.
REQ-025 Conversion SHALL be a sub-module bin2bcd_seq (start, bin in, busy, done, bcd[15:0] out); scan and blanking stay in the top.
REQ-026 The top SHALL drive one SevenSegmentDecoder instance downstream only at system level, not inside this block.

Verification
REQ-027 Reset then load 1234 (SCAN_DIV=4) -> busy high 15 cycles; over one scan period digit_sel 0001/0010/0100/1000 shows 4/3/2/1.
REQ-028 Load 7 with BLANK_LZ=1 -> digits show 7,F,F,F; load 0 -> 0,F,F,F; load 1005 -> 5,0,0,1 (inner zeros not blanked).
REQ-029 Load 12000 -> overflow 1, display 9,9,9,9; subsequent load 42 -> overflow 0.
REQ-030 Load 1234, then load 5678 at busy cycle 5 -> second load ignored; display ends 1234.
REQ-031 rst_n low at SHIFT cycle 7 of load 9999 -> busy 0, display 0000 immediately, digit_sel 0001.
REQ-032 SCAN_DIV=4 continuous run -> digit_sel changes exactly every 4 cycles, always one-hot, across a load/COMMIT boundary.
